cal_seq: RTL and testbench

CAL_SEQ -- requirements
Module: cal_seq

---
 rtl/cal_seq.sv | 160 ++++++++++++++++
 tb/tb_cal_seq.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cal_seq.sv
// Calibration pass sequencer: walks every bin, pairs it with a strided twiddle,
// feeds both to an external butterfly calculator and streams back the results.
module cal_seq #(
  parameter int unsigned N_BINS  = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [23:0]       delta,
  input  logic [ADDR_W-1:0] step,
  output logic              bin_rd,
  output logic [ADDR_W-1:0] bin_addr,
  input  logic [23:0]       bin_real,
  input  logic [23:0]       bin_imag,
  output logic              twid_rd,
  output logic [ADDR_W-1:0] twid_addr,
  input  logic [23:0]       twid_real,
  input  logic [23:0]       twid_imag,
  output logic              cal_en,
  output logic [23:0]       cal_freq_real,
  output logic [23:0]       cal_freq_imag,
  output logic [23:0]       cal_twid_real,
  output logic [23:0]       cal_twid_imag,
  output logic [23:0]       cal_delta,
  input  logic [23:0]       cal_out,
  input  logic              cal_done,
  output logic              res_valid,
  output logic [23:0]       res_data,
  output logic [ADDR_W-1:0] res_index,
  output logic              busy,
  output logic              finished,
  output logic              error
);

  localparam int unsigned WCNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(N_BINS - 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAITRD, ISSUE, WAITCAL, STORE, DONE, ERR
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] k;
  logic [ADDR_W-1:0] tp;
  logic [ADDR_W-1:0] step_q;
  logic [WCNT_W-1:0] wcnt;

  // Operands are only rewritten in WAITRD, so they stay put across ISSUE..STORE
  // as the non-latching calculator requires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      k             <= '0;
      tp            <= '0;
      step_q        <= '0;
      wcnt          <= '0;
      bin_rd        <= 1'b0;
      bin_addr      <= '0;
      twid_rd       <= 1'b0;
      twid_addr     <= '0;
      cal_en        <= 1'b0;
      cal_freq_real <= '0;
      cal_freq_imag <= '0;
      cal_twid_real <= '0;
      cal_twid_imag <= '0;
      cal_delta     <= '0;
      res_valid     <= 1'b0;
      res_data      <= '0;
      res_index     <= '0;
      busy          <= 1'b0;
      finished      <= 1'b0;
      error         <= 1'b0;
    end else begin
      bin_rd    <= 1'b0;
      twid_rd   <= 1'b0;
      cal_en    <= 1'b0;
      res_valid <= 1'b0;
      finished  <= 1'b0;
      if (state != IDLE && abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              k         <= '0;
              tp        <= '0;
              step_q    <= step;
              cal_delta <= delta;
              error     <= 1'b0;
              bin_addr  <= '0;
              twid_addr <= '0;
              bin_rd    <= 1'b1;
              twid_rd   <= 1'b1;
              busy      <= 1'b1;
              state     <= FETCH;
            end
          end
          FETCH: state <= WAITRD;
          WAITRD: begin
            cal_freq_real <= bin_real;
            cal_freq_imag <= bin_imag;
            cal_twid_real <= twid_real;
            cal_twid_imag <= twid_imag;
            cal_en        <= 1'b1;
            state         <= ISSUE;
          end
          ISSUE: begin
            wcnt  <= '0;
            state <= WAITCAL;
          end
          WAITCAL: begin
            if (cal_done) begin
              res_data  <= cal_out;
              res_index <= k;
              res_valid <= 1'b1;
              state     <= STORE;
            end else if (wcnt == WAIT_LAST) begin
              error <= 1'b1;
              state <= ERR;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
          STORE: begin
            if (k == LAST_BIN) begin
              finished <= 1'b1;
              state    <= DONE;
            end else begin
              k         <= k + 1'b1;
              tp        <= tp + step_q;
              bin_addr  <= k + 1'b1;
              twid_addr <= tp + step_q;
              bin_rd    <= 1'b1;
              twid_rd   <= 1'b1;
              state     <= FETCH;
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          ERR: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cal_seq.sv
// Bench for cal_seq: table-driven passes with random memory contents checked
// against an index/stride reference, plus hand-written abort/timeout/reset cases.
module tb_cal_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [23:0] delta = '0;
  logic [3:0]  step = '0;
  logic        bin_rd, twid_rd, cal_en, res_valid, busy, finished, error;
  logic [3:0]  bin_addr, twid_addr, res_index;
  logic [23:0] bin_real = '0, bin_imag = '0, twid_real = '0, twid_imag = '0;
  logic [23:0] cal_freq_real, cal_freq_imag, cal_twid_real, cal_twid_imag, cal_delta;
  logic [23:0] cal_out, res_data;
  logic        cal_done;

  cal_seq #(.N_BINS(16), .ADDR_W(4), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .delta(delta), .step(step),
    .bin_rd(bin_rd), .bin_addr(bin_addr), .bin_real(bin_real), .bin_imag(bin_imag),
    .twid_rd(twid_rd), .twid_addr(twid_addr), .twid_real(twid_real), .twid_imag(twid_imag),
    .cal_en(cal_en), .cal_freq_real(cal_freq_real), .cal_freq_imag(cal_freq_imag),
    .cal_twid_real(cal_twid_real), .cal_twid_imag(cal_twid_imag), .cal_delta(cal_delta),
    .cal_out(cal_out), .cal_done(cal_done), .res_valid(res_valid), .res_data(res_data),
    .res_index(res_index), .busy(busy), .finished(finished), .error(error)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] calc_fn(input logic [23:0] fr, input logic [23:0] fi,
                                          input logic [23:0] tr, input logic [23:0] ti,
                                          input logic [23:0] d);
    return (fr + d) ^ {fi[11:0], fi[23:12]} ^ (tr + (ti << 1));
  endfunction

  // Memories and calculator model (lat_cfg = 0 means the calculator never answers)
  logic [23:0] mem_r[16], mem_i[16], tw_r[16], tw_i[16];
  int unsigned lat_cfg = 7;
  int unsigned ccnt = 0;

  always @(posedge clk) begin
    if (bin_rd) begin
      bin_real <= mem_r[bin_addr];
      bin_imag <= mem_i[bin_addr];
    end
    if (twid_rd) begin
      twid_real <= tw_r[twid_addr];
      twid_imag <= tw_i[twid_addr];
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ccnt <= 0;
    else if (cal_en) ccnt <= lat_cfg;
    else if (ccnt != 0) ccnt <= ccnt - 1;
  end

  assign cal_done = (ccnt == 1);
  assign cal_out  = calc_fn(cal_freq_real, cal_freq_imag, cal_twid_real, cal_twid_imag, cal_delta);

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference for the current pass
  logic [3:0]  cur_step;
  logic [23:0] exp_data[16];
  int unsigned res_cnt, rd_cnt, fin_cnt, fin_cyc, pass_cyc0, last_res, last_done;
  bit          have_done, holding, post;
  logic [23:0] hold_val;

  task automatic monitor();
    if (!busy) holding = 0;
    if (holding) begin
      check("operand_hold", cal_freq_real, hold_val);
      if (post) holding = 0;
      else if (cal_done) post = 1;
    end
    if (cal_en) begin
      holding  = 1;
      post     = 0;
      hold_val = cal_freq_real;
      if (have_done) check("pacing", (cyc - last_done) >= 4, 1);
    end
    if (cal_done) begin
      have_done = 1;
      last_done = cyc;
    end
    if (twid_rd) begin
      check("read_in_range", rd_cnt < 16, 1);
      check("bin_rd_with_twid", bin_rd, 1);
      check("bin_addr", bin_addr, rd_cnt % 16);
      check("twid_addr", twid_addr, (rd_cnt * cur_step) % 16);
      rd_cnt++;
    end
    if (res_valid) begin
      check("result_in_range", res_cnt < 16, 1);
      check("res_index", res_index, res_cnt % 16);
      if (res_cnt < 16) check("res_data", res_data, exp_data[res_cnt]);
      if (res_cnt > 0 && lat_cfg > 0) check("bin_latency", cyc - last_res, 4 + lat_cfg);
      last_res = cyc;
      res_cnt++;
    end
    if (finished) begin
      fin_cnt++;
      fin_cyc = cyc;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic check_quiet_outputs(input string tag);
    check({tag, "_ctrl"}, {bin_rd, twid_rd, cal_en, res_valid, busy, finished, error,
                           bin_addr, twid_addr, res_index}, 0);
    check({tag, "_freq_re"}, cal_freq_real, 0);
    check({tag, "_freq_im"}, cal_freq_imag, 0);
    check({tag, "_twid_re"}, cal_twid_real, 0);
    check({tag, "_twid_im"}, cal_twid_imag, 0);
    check({tag, "_delta"}, cal_delta, 0);
    check({tag, "_res_data"}, res_data, 0);
  endtask

  task automatic start_pass(input logic [3:0] st, input logic [23:0] d,
                            input int unsigned lt, input bit idx);
    lat_cfg  = lt;
    cur_step = st;
    for (int i = 0; i < 16; i++) begin
      mem_r[i] = idx ? 24'(i) : 24'($urandom);
      mem_i[i] = idx ? 24'(i) : 24'($urandom);
      tw_r[i]  = idx ? 24'(i) : 24'($urandom);
      tw_i[i]  = idx ? 24'(i) : 24'($urandom);
    end
    for (int kk = 0; kk < 16; kk++) begin
      int unsigned t;
      t = (kk * int'(st)) % 16;
      exp_data[kk] = calc_fn(mem_r[kk], mem_i[kk], tw_r[t], tw_i[t], d);
    end
    res_cnt = 0; rd_cnt = 0; fin_cnt = 0; fin_cyc = 0;
    have_done = 0; holding = 0; post = 0;
    pass_cyc0 = cyc;
    delta = d;
    step  = st;
    start = 1'b1;
    tick();
    start = 1'b0;
    delta = 24'($urandom);
    step  = 4'($urandom);
  endtask

  typedef struct {
    logic [3:0]  step;
    logic [23:0] delta;
    int unsigned lat;
    bit          idx_data;
    int unsigned exp_len;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{4'd1,  24'h000000, 7,  1'b1, 178};
    vecs[1] = '{4'd5,  24'h3A5C71, 7,  1'b0, 178};
    vecs[2] = '{4'd0,  24'hFFFFFF, 1,  1'b0, 82};
    vecs[3] = '{4'd15, 24'h800001, 3,  1'b0, 114};
    vecs[4] = '{4'd8,  24'h123456, 12, 1'b0, 258};

    #12;
    check_quiet_outputs("por");
    rst_n = 1'b1;
    tick();
    check_quiet_outputs("idle");

    foreach (vecs[v]) begin
      int unsigned guard;
      start_pass(vecs[v].step, vecs[v].delta, vecs[v].lat, vecs[v].idx_data);
      check("busy_after_start", busy, 1);
      guard = 0;
      while (fin_cnt == 0 && guard < vecs[v].exp_len + 50) begin
        tick();
        guard++;
      end
      check("pass_finished", fin_cnt, 1);
      check("pass_length", fin_cyc - pass_cyc0 + 1, vecs[v].exp_len);
      check("pass_results", res_cnt, 16);
      check("pass_reads", rd_cnt, 16);
      check("delta_latched", cal_delta, vecs[v].delta);
      tick();
      check("idle_after_done", {busy, finished}, 2'b00);
      tick();
      check("single_finished", fin_cnt, 1);
    end

    // start together with abort in IDLE is ignored
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort_ignored", {busy, bin_rd}, 2'b00);

    // calculator never answers: timeout into ERR
    begin
      int unsigned guard, s;
      start_pass(4'd3, 24'($urandom), 0, 0);
      guard = 0;
      while (!cal_en && guard < 20) begin tick(); guard++; end
      check("timeout_cal_en_seen", cal_en, 1);
      s = cyc;
      while (cyc < s + 255) tick();
      check("timeout_not_yet", {error, busy}, 2'b01);
      tick();
      check("timeout_err_state", {error, busy}, 2'b11);
      tick();
      check("timeout_idle", {error, busy}, 2'b10);
      check("timeout_no_result", res_cnt, 0);
      check("timeout_no_finished", fin_cnt, 0);
      start_pass(4'd2, 24'($urandom), 7, 0);
      check("error_cleared_by_start", {error, busy}, 2'b01);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_in_fetch", {busy, error}, 2'b00);
    end

    // abort coinciding with cal_done in bin 3
    begin
      int unsigned guard;
      start_pass(4'd7, 24'($urandom), 7, 0);
      guard = 0;
      while (res_cnt < 3 && guard < 100) begin tick(); guard++; end
      check("abort_reached_bin3", res_cnt, 3);
      guard = 0;
      while (!cal_en && guard < 20) begin tick(); guard++; end
      check("abort_bin3_cal_en", cal_en, 1);
      repeat (7) tick();
      check("abort_cal_done_now", cal_done, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_idle", {busy, res_valid, cal_en, finished}, 4'b0000);
      repeat (10) tick();
      check("abort_no_result", res_cnt, 3);
      check("abort_no_finished", fin_cnt, 0);
    end

    // extra start while busy, then reset during bin 7
    begin
      int unsigned guard;
      start_pass(4'd1, 24'($urandom), 7, 0);
      repeat (5) tick();
      delta = 24'($urandom);
      start = 1'b1;
      tick();
      start = 1'b0;
      guard = 0;
      while (res_cnt < 7 && guard < 200) begin tick(); guard++; end
      check("reset_reached_bin7", res_cnt, 7);
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      check_quiet_outputs("midreset");
      tick();
      rst_n = 1'b1;
      repeat (20) tick();
      check("reset_no_result", res_cnt, 7);
      check("reset_no_finished", fin_cnt, 0);
      check_quiet_outputs("post_reset");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
